// File: rtl/coherence_bus_ctrl.sv
// Two-core MSI coherence bus controller: arbitrates both dcaches onto one RAM port and
// sequences snoop / cache-to-cache transfers. Define CC_ROUND_ROBIN_EN for round-robin ties.
module coherence_bus_ctrl #(
  parameter int unsigned BLK_WORDS = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       ccwrite,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ramwait
);

  localparam int unsigned   CW   = $clog2(BLK_WORDS);
  localparam logic [CW-1:0] LAST = CW'(BLK_WORDS - 1);

  typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, FILL} state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef CC_ROUND_ROBIN_EN
  logic          prio_q, prio_d;
`endif
  logic [1:0]    req;
  logic          pick, r, s, beat_done;

  always_comb begin
    req = cctrans | dREN | dWEN;
    r   = grant_q;
    s   = ~grant_q;
`ifdef CC_ROUND_ROBIN_EN
    pick = (req == 2'b11) ? prio_q : ~req[0];
`else
    pick = ~req[0];
`endif
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    beat_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|req) begin
          grant_d = pick;
          if (cctrans[pick])   state_d = SNOOP;
          else if (dWEN[pick]) state_d = WB;
          else                 state_d = FILL;
        end
      end
      SNOOP: begin
        if (ccwrite[s])                    state_d = C2C;
        else if (ccwrite[r] && !dREN[r])   state_d = IDLE;
        else                               state_d = FILL;
      end
      WB, FILL: beat_done = !ramwait;
      C2C:      beat_done = !ramwait && dWEN[s];
      default:  state_d = IDLE;
    endcase
    // A dropped request still lets the in-flight beat finish before leaving.
    if (beat_done) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST || !req[r]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
`ifdef CC_ROUND_ROBIN_EN
    prio_d = prio_q;
    if (state_q != IDLE && state_d == IDLE) prio_d = ~grant_q;
`endif
  end

  // Outputs decode the registered state so beat handshakes complete in the ramwait=0 cycle.
  always_comb begin
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state_q)
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[r];
        ramstore = dstore[r];
        dwait[r] = ramwait;
      end
      FILL: begin
        ramREN   = 1'b1;
        ramaddr  = daddr[r];
        dload[r] = ramload;
        dwait[r] = ramwait;
      end
      SNOOP: begin
        ccwait[s]      = 1'b1;
        ccsnoopaddr[s] = daddr[r];
        ccinv[s]       = ccwrite[r];
      end
      C2C: begin
        ccwait[s] = 1'b1;
        ramWEN    = dWEN[s];
        ramaddr   = daddr[s];
        ramstore  = dstore[s];
        dload[r]  = dstore[s];
        dwait[r]  = ~beat_done;
        dwait[s]  = ~beat_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      cnt_q   <= '0;
`ifdef CC_ROUND_ROBIN_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
`ifdef CC_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

endmodule
